// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared FSM state and owner id definitions for dmem_arbiter
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic OWN_CPU = 1'b0;
  localparam logic OWN_DBG = 1'b1;

endpackage

// File: rtl/dmem_arb_pick.sv
// rtl/dmem_arb_pick.sv - combinational 2-input grant selector; on contention the port not granted last wins
module dmem_arb_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req_i,   // bit 0 = CPU, bit 1 = DBG
  input  logic       last_i,
  output logic       win_o
);

  always_comb begin
    win_o = OWN_CPU;
    if (req_i[0] && req_i[1]) begin
      win_o = (last_i == OWN_CPU) ? OWN_DBG : OWN_CPU;
    end else if (req_i[1]) begin
      win_o = OWN_DBG;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU/DBG data-memory arbiter, IDLE->ACCESS->RESP per word access
// DMEM_ARB_RR_EN defined: round-robin arbitration; undefined: fixed priority, CPU first.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_stall,
  output logic              err,
  output logic [ADDR_W-1:0] mem_access_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              mis_q, mis_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wen_q, wen_d;
  logic              ren_q, ren_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              dbg_ack_q, dbg_ack_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dbg_rdata_q, dbg_rdata_d;
  logic              last_q;
  logic              win;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_mis;
  logic [DATA_W-1:0] resp_data;

`ifdef DMEM_ARB_RR_EN
  logic last_d;
`else
  assign last_q = OWN_DBG;
`endif

  dmem_arb_pick u_pick (
    .req_i  ({dbg_req, cpu_req}),
    .last_i (last_q),
    .win_o  (win)
  );

  assign sel_we    = (win == OWN_DBG) ? dbg_we    : cpu_we;
  assign sel_addr  = (win == OWN_DBG) ? dbg_addr  : cpu_addr;
  assign sel_wdata = (win == OWN_DBG) ? dbg_wdata : cpu_wdata;
  assign sel_mis   = (sel_addr[1:0] != 2'b00);
  // writes and misaligned accesses return zero data
  assign resp_data = ren_q ? mem_read_data : '0;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mis_d       = mis_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    cpu_ack_d   = 1'b0;
    dbg_ack_d   = 1'b0;
    err_d       = 1'b0;
    cpu_rdata_d = '0;
    dbg_rdata_d = '0;
`ifdef DMEM_ARB_RR_EN
    last_d      = last_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dbg_req) begin
          state_d = ST_ACCESS;
          owner_d = win;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          mis_d   = sel_mis;
          wen_d   = sel_we & ~sel_mis;
          ren_d   = ~sel_we & ~sel_mis;
`ifdef DMEM_ARB_RR_EN
          last_d  = win;
`endif
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        err_d   = mis_q;
        if (owner_q == OWN_DBG) begin
          dbg_ack_d   = 1'b1;
          dbg_rdata_d = resp_data;
        end else begin
          cpu_ack_d   = 1'b1;
          cpu_rdata_d = resp_data;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_CPU;
      mis_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      cpu_ack_q   <= 1'b0;
      dbg_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mis_q       <= mis_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      cpu_ack_q   <= cpu_ack_d;
      dbg_ack_q   <= dbg_ack_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dbg_rdata_q <= dbg_rdata_d;
    end
  end

`ifdef DMEM_ARB_RR_EN
  // DBG-last at reset so the CPU wins the first contention
  always_ff @(posedge clk) begin
    if (reset) last_q <= OWN_DBG;
    else       last_q <= last_d;
  end
`endif

  assign mem_access_addr = addr_q;
  assign mem_write_data  = wdata_q;
  assign mem_write_en    = wen_q;
  assign mem_read_en     = ren_q;
  assign cpu_ack         = cpu_ack_q;
  assign dbg_ack         = dbg_ack_q;
  assign cpu_rdata       = cpu_rdata_q;
  assign dbg_rdata       = dbg_rdata_q;
  assign err             = err_q;
  assign cpu_stall       = cpu_req & ~cpu_ack_q;
  assign dbg_stall       = dbg_req & ~dbg_ack_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural data memory and reference model
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 0, cpu_we = 0, dbg_req = 0, dbg_we = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, dbg_addr = 0, dbg_wdata = 0;
  logic        cpu_ack, dbg_ack, cpu_stall, dbg_stall, err;
  logic [31:0] cpu_rdata, dbg_rdata;
  logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
  logic        mem_write_en, mem_read_en;
  logic        mem_clear = 1'b0;

  logic [31:0] mem    [0:255];
  logic [31:0] refmem [0:255];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata), .dbg_stall(dbg_stall),
    .err(err),
    .mem_access_addr(mem_access_addr), .mem_write_data(mem_write_data),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_read_data(mem_read_data)
  );

  // data_mem stand-in: combinational read, write on the rising edge
  assign mem_read_data = mem[mem_access_addr[9:2]];
  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (mem_write_en) begin
      mem[mem_access_addr[9:2]] <= mem_write_data;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cpu_req = 0; dbg_req = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_single(input bit p, input bit we, input logic [31:0] a, input logic [31:0] wd,
                            output int ack_k, output int wen_cnt, output int ren_cnt,
                            output logic [31:0] wen_addr, output logic [31:0] wen_data,
                            output logic [31:0] rd, output int err_cnt, output logic err_at_ack,
                            output int stall_cnt, output int other_ack);
    ack_k = -1; wen_cnt = 0; ren_cnt = 0; wen_addr = '0; wen_data = '0; rd = 'x;
    err_cnt = 0; err_at_ack = 1'b0; stall_cnt = 0; other_ack = 0;
    @(negedge clk);
    if (p) begin dbg_req = 1; dbg_we = we; dbg_addr = a; dbg_wdata = wd; end
    else   begin cpu_req = 1; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
    #1;
    if ((p ? dbg_stall : cpu_stall) === 1'b1) stall_cnt++;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (mem_write_en === 1'b1) begin wen_cnt++; wen_addr = mem_access_addr; wen_data = mem_write_data; end
      if (mem_read_en === 1'b1) ren_cnt++;
      if (err === 1'b1) err_cnt++;
      if (ack_k < 0 && (p ? dbg_stall : cpu_stall) === 1'b1) stall_cnt++;
      if ((p ? cpu_ack : dbg_ack) === 1'b1) other_ack++;
      if ((p ? dbg_ack : cpu_ack) === 1'b1 && ack_k < 0) begin
        ack_k = k;
        rd = p ? dbg_rdata : cpu_rdata;
        err_at_ack = err;
        if (p) dbg_req = 0; else cpu_req = 0;
      end
    end
    cpu_req = 0; dbg_req = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1; mem_clear = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cpu_ack, dbg_ack, err, mem_write_en, mem_read_en, cpu_stall, dbg_stall} !== 7'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 0000000",
        {cpu_ack, dbg_ack, err, mem_write_en, mem_read_en, cpu_stall, dbg_stall});
    end
    n_cmp++;
    if ({mem_access_addr, mem_write_data} !== 64'h0) begin
      n_fail++; $display("FAIL reset_mem_bus: addr=%h wdata=%h expected 0", mem_access_addr, mem_write_data);
    end
    n_cmp++;
    if ({cpu_rdata, dbg_rdata} !== 64'h0) begin
      n_fail++; $display("FAIL reset_rdata: cpu=%h dbg=%h expected 0", cpu_rdata, dbg_rdata);
    end
    reset = 1'b0; mem_clear = 1'b0;
    for (int i = 0; i < 256; i++) refmem[i] = '0;
  endtask

  task automatic test_idle();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({mem_write_en, mem_read_en, cpu_ack, dbg_ack, err} !== 5'b0) begin
        n_fail++; $display("FAIL idle_quiet cycle %0d: got %b expected 00000", k,
          {mem_write_en, mem_read_en, cpu_ack, dbg_ack, err});
      end
    end
  endtask

  task automatic test_cpu_write();
    int ak, wc, rc, ec, sc, oa; logic [31:0] wa, wdat, rd; logic ea;
    run_single(0, 1, 32'h10, 32'hDEADBEEF, ak, wc, rc, wa, wdat, rd, ec, ea, sc, oa);
    refmem[4] = 32'hDEADBEEF;
    n_cmp++; if (ak !== 2) begin n_fail++; $display("FAIL wr_ack_latency: got %0d expected 2", ak); end
    n_cmp++; if (wc !== 1) begin n_fail++; $display("FAIL wr_wen_count: got %0d expected 1", wc); end
    n_cmp++; if (wa !== 32'h10) begin n_fail++; $display("FAIL wr_addr: got %h expected 00000010", wa); end
    n_cmp++; if (wdat !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_data: got %h expected deadbeef", wdat); end
    n_cmp++; if (sc !== 2) begin n_fail++; $display("FAIL wr_stall_cycles: got %0d expected 2", sc); end
    n_cmp++; if (rc !== 0 || ec !== 0 || oa !== 0) begin
      n_fail++; $display("FAIL wr_side_effects: ren=%0d err=%0d dbg_ack=%0d expected 0", rc, ec, oa);
    end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_mem: got %h expected deadbeef", mem[4]); end
  endtask

  task automatic test_cpu_read();
    int ak, wc, rc, ec, sc, oa; logic [31:0] wa, wdat, rd; logic ea;
    run_single(0, 0, 32'h10, 32'h0, ak, wc, rc, wa, wdat, rd, ec, ea, sc, oa);
    n_cmp++; if (ak !== 2) begin n_fail++; $display("FAIL rd_ack_latency: got %0d expected 2", ak); end
    n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data: got %h expected deadbeef", rd); end
    n_cmp++; if (rc !== 1 || wc !== 0) begin
      n_fail++; $display("FAIL rd_strobes: ren=%0d wen=%0d expected 1/0", rc, wc);
    end
  endtask

  task automatic test_misaligned();
    int ak, wc, rc, ec, sc, oa; logic [31:0] wa, wdat, rd; logic ea;
    run_single(1, 1, 32'h12, 32'h12345678, ak, wc, rc, wa, wdat, rd, ec, ea, sc, oa);
    n_cmp++; if (ak !== 2) begin n_fail++; $display("FAIL mis_wr_ack: got %0d expected 2", ak); end
    n_cmp++; if (ea !== 1'b1 || ec !== 1) begin
      n_fail++; $display("FAIL mis_wr_err: at_ack=%b pulses=%0d expected 1/1", ea, ec);
    end
    n_cmp++; if (wc !== 0) begin n_fail++; $display("FAIL mis_wr_wen: got %0d expected 0", wc); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL mis_wr_rdata: got %h expected 0", rd); end
    n_cmp++; if (mem[4] !== 32'hDEADBEEF) begin n_fail++; $display("FAIL mis_wr_mem: got %h expected deadbeef", mem[4]); end
    run_single(0, 0, 32'h13, 32'h0, ak, wc, rc, wa, wdat, rd, ec, ea, sc, oa);
    n_cmp++; if (ak !== 2 || ea !== 1'b1 || rd !== 32'h0 || rc !== 0) begin
      n_fail++; $display("FAIL mis_rd: ack=%0d err=%b rdata=%h ren=%0d expected 2/1/0/0", ak, ea, rd, rc);
    end
  endtask

  task automatic test_reset_access();
    @(negedge clk);
    cpu_req = 1; cpu_we = 1; cpu_addr = 32'h20; cpu_wdata = 32'h5;
    @(negedge clk);
    n_cmp++; if (mem_write_en !== 1'b1) begin n_fail++; $display("FAIL rst_acc_wen: got %b expected 1", mem_write_en); end
    reset = 1'b1;
    @(negedge clk);
    refmem[8] = 32'h5;
    n_cmp++; if (mem[8] !== 32'h5) begin n_fail++; $display("FAIL rst_acc_mem: got %h expected 00000005", mem[8]); end
    n_cmp++; if ({cpu_ack, dbg_ack, err, mem_write_en, mem_read_en} !== 5'b0) begin
      n_fail++; $display("FAIL rst_acc_flags: got %b expected 00000",
        {cpu_ack, dbg_ack, err, mem_write_en, mem_read_en});
    end
    n_cmp++; if ({mem_access_addr, mem_write_data, cpu_rdata} !== 96'h0) begin
      n_fail++; $display("FAIL rst_acc_bus: addr=%h wdata=%h rdata=%h expected 0", mem_access_addr, mem_write_data, cpu_rdata);
    end
    reset = 1'b0; cpu_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_cmp++; if ({cpu_ack, mem_write_en, mem_read_en} !== 3'b0) begin
        n_fail++; $display("FAIL rst_acc_after cycle %0d: got %b expected 000", k, {cpu_ack, mem_write_en, mem_read_en});
      end
    end
  endtask

  task automatic test_contention();
    int exp_ck, exp_dk, ck, dk, both;
    int ak, wc, rc, ec, sc, oa; logic [31:0] wa, wdat, rd; logic ea;
    logic [31:0] crd, drd;
    do_reset();
    for (int r = 0; r < 2; r++) begin
      if (r == 1) begin
        run_single(0, 0, 32'h20, 32'h0, ak, wc, rc, wa, wdat, rd, ec, ea, sc, oa);
        n_cmp++; if (ak !== 2 || rd !== refmem[8]) begin
          n_fail++; $display("FAIL cont_solo: ack=%0d rdata=%h expected 2/%h", ak, rd, refmem[8]);
        end
      end
      exp_ck = 2; exp_dk = 5;
`ifdef DMEM_ARB_RR_EN
      if (r == 1) begin exp_ck = 5; exp_dk = 2; end
`endif
      ck = -1; dk = -1; both = 0; crd = 'x; drd = 'x;
      @(negedge clk);
      cpu_req = 1; cpu_we = 0; cpu_addr = 32'h10;
      dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
      for (int k = 1; k <= 10; k++) begin
        @(negedge clk);
        if (cpu_ack === 1'b1 && dbg_ack === 1'b1) both++;
        if (k == 3) begin
          n_cmp++; if ((exp_ck > exp_dk ? cpu_stall : dbg_stall) !== 1'b1) begin
            n_fail++; $display("FAIL cont_loser_stall round %0d: got 0 expected 1", r);
          end
        end
        if (cpu_ack === 1'b1 && ck < 0) begin ck = k; crd = cpu_rdata; cpu_req = 0; end
        if (dbg_ack === 1'b1 && dk < 0) begin dk = k; drd = dbg_rdata; dbg_req = 0; end
      end
      cpu_req = 0; dbg_req = 0;
      n_cmp++; if (ck !== exp_ck || dk !== exp_dk) begin
        n_fail++; $display("FAIL cont_order round %0d: cpu_ack@%0d dbg_ack@%0d expected %0d/%0d", r, ck, dk, exp_ck, exp_dk);
      end
      n_cmp++; if (crd !== refmem[4] || drd !== refmem[8] || both !== 0) begin
        n_fail++; $display("FAIL cont_data round %0d: cpu=%h dbg=%h both=%0d expected %h/%h/0", r, crd, drd, both, refmem[4], refmem[8]);
      end
    end
  endtask

  task automatic test_random();
    bit act[2]; bit w[2]; logic [31:0] ad[2]; logic [31:0] wd[2]; int gap[2]; int wt[2];
    logic ackv[2]; logic [31:0] rdv[2]; logic stv[2];
    logic [31:0] exp_rd; bit exp_err; bit stop; int n_acc; int mism;
    stop = 0; n_acc = 0; mism = 0;
    for (int p = 0; p < 2; p++) begin act[p] = 0; gap[p] = $urandom_range(0, 3); wt[p] = 0; end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      ackv[0] = cpu_ack; ackv[1] = dbg_ack;
      rdv[0] = cpu_rdata; rdv[1] = dbg_rdata;
      stv[0] = cpu_stall; stv[1] = dbg_stall;
      if (cyc >= 1500) stop = 1;
      n_cmp++; if ((cpu_ack & dbg_ack) !== 1'b0 || (mem_write_en & mem_read_en) !== 1'b0) begin
        n_fail++; $display("FAIL rnd_exclusive cycle %0d: acks=%b%b strobes=%b%b", cyc, cpu_ack, dbg_ack, mem_write_en, mem_read_en);
      end
      for (int p = 0; p < 2; p++) begin
        if (act[p]) begin
          if (ackv[p] === 1'b1) begin
            exp_err = (ad[p][1:0] != 2'b00);
            exp_rd = (w[p] || exp_err) ? 32'h0 : refmem[ad[p][9:2]];
            n_cmp++; if (rdv[p] !== exp_rd || err !== exp_err) begin
              n_fail++; $display("FAIL rnd_resp port %0d addr %h: rdata=%h err=%b expected %h/%b", p, ad[p], rdv[p], err, exp_rd, exp_err);
            end
            if (w[p] && !exp_err) refmem[ad[p][9:2]] = wd[p];
            act[p] = 0; gap[p] = $urandom_range(0, 3); n_acc++;
            if (p == 0) cpu_req = 0; else dbg_req = 0;
          end else begin
            wt[p]++;
            n_cmp++; if (stv[p] !== 1'b1 || rdv[p] !== 32'h0) begin
              n_fail++; $display("FAIL rnd_pending port %0d: stall=%b rdata=%h expected 1/0", p, stv[p], rdv[p]);
            end
            if (wt[p] > 200) begin
              n_cmp++; n_fail++;
              $display("FAIL rnd_timeout port %0d: no ack after %0d cycles, expected ack", p, wt[p]);
              act[p] = 0;
              if (p == 0) cpu_req = 0; else dbg_req = 0;
            end
          end
        end else begin
          n_cmp++; if ({ackv[p], stv[p], rdv[p]} !== 34'h0) begin
            n_fail++; $display("FAIL rnd_idle_port %0d: ack=%b stall=%b rdata=%h expected 0", p, ackv[p], stv[p], rdv[p]);
          end
          if (!stop) begin
            if (gap[p] > 0) gap[p]--;
            else begin
              act[p] = 1; wt[p] = 0;
              w[p] = 1'($urandom_range(0, 1));
              ad[p] = 32'($urandom_range(0, 255)) << 2;
              if ($urandom_range(0, 7) == 0) ad[p][1:0] = 2'($urandom_range(1, 3));
              wd[p] = $urandom;
              if (p == 0) begin cpu_req = 1; cpu_we = w[p]; cpu_addr = ad[p]; cpu_wdata = wd[p]; end
              else        begin dbg_req = 1; dbg_we = w[p]; dbg_addr = ad[p]; dbg_wdata = wd[p]; end
            end
          end
        end
      end
      if (stop && !act[0] && !act[1]) break;
    end
    n_cmp++; if (act[0] || act[1] || n_acc < 100) begin
      n_fail++; $display("FAIL rnd_drain: pending=%b%b accesses=%0d expected 00 and >=100", act[0], act[1], n_acc);
    end
    for (int i = 0; i < 256; i++) if (mem[i] !== refmem[i]) mism++;
    n_cmp++; if (mism !== 0) begin
      n_fail++; $display("FAIL rnd_mem_image: %0d words differ, expected 0", mism);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_cpu_write();
    test_cpu_read();
    test_misaligned();
    test_reset_access();
    test_contention();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
